// File: rtl/norm_pkg.sv
// ---------------------------------------------------------------------------
// norm_pkg
// Shared definitions for the vertex normalization (perspective-divide)
// sequencer: FSM state encoding, data-format defaults, saturation constants,
// iteration counts and the component-index to vertex/axis mapping.
// No ports (package).
// ---------------------------------------------------------------------------
package norm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOAD,
        S_DIV,
        S_STORE,
        S_HOLD
    } state_t;

    localparam int          DATA_W          = 16;
    localparam int          NUM_W           = 24;
    localparam int          FRAC_BITS_DEF   = 8;
    localparam logic [3:0]  READY_STATE_DEF = 4'd5;
    localparam int          NUM_COMP        = 12;
    localparam int          DIV_ITERS       = 24;

    localparam logic signed [DATA_W-1:0] SAT_POS = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_NEG = 16'sh8001;

    // Components are ordered v1 X,Y,Z, v2 X,Y,Z, ... v4 Z.
    function automatic logic [1:0] comp_vertex(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2:  return 2'd0;
            4'd3, 4'd4, 4'd5:  return 2'd1;
            4'd6, 4'd7, 4'd8:  return 2'd2;
            default:           return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] comp_axis(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6, 4'd9:  return 2'd0;
            4'd1, 4'd4, 4'd7, 4'd10: return 2'd1;
            default:                 return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/norm_serial_div.sv
// ---------------------------------------------------------------------------
// norm_serial_div
// Unsigned 24/16 restoring divider, one quotient bit per clock.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   start in   load operands and begin (one-cycle pulse)
//   num   in   24-bit unsigned dividend
//   den   in   16-bit unsigned divisor (0 yields an all-ones quotient)
//   done  out  high during the cycle whose edge retires the last iteration
//   quo   out  24-bit quotient, final from the cycle after done
// ---------------------------------------------------------------------------
module norm_serial_div
    import norm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] num,
    input  logic [15:0] den,
    output logic        done,
    output logic [23:0] quo
);

    logic [23:0] q;
    logic [15:0] rem;
    logic [15:0] den_r;
    logic [4:0]  cnt;
    logic        running;
    logic [16:0] trial;
    logic        fits;

    // The dividend shifts out of q from the top while quotient bits shift in
    // from the bottom, so q doubles as the dividend register.
    assign trial = {rem, q[23]};
    assign fits  = (trial >= {1'b0, den_r});
    assign done  = running && (cnt == 5'(DIV_ITERS - 1));
    assign quo   = q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            rem     <= '0;
            den_r   <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            q       <= num;
            rem     <= '0;
            den_r   <= den;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            // The remainder always fits in 16 bits since it stays below den.
            rem <= fits ? 16'(trial - {1'b0, den_r}) : trial[15:0];
            q   <= {q[22:0], fits};
            cnt <= cnt + 5'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/norm_divide_sched.sv
// ---------------------------------------------------------------------------
// norm_divide_sched
// Perspective-divide sequencer: latches a 4x4 clip-space matrix (row i =
// vertex i: X, Y, Z, W) on entry of matrix_state into READY_STATE, computes
// the 12 quotients X/W, Y/W, Z/W on one shared serial divider, and presents
// the normalized vertices through a valid/ready handshake.
// Ports:
//   CLK, rst            clock, synchronous active-high reset
//   matrix_state[3:0]   matrix unit state; rising into READY_STATE triggers
//   d11..d44            signed Q8.8 matrix entries, dij = vertex i, axis j
//   out_ready           downstream accepts the result
//   out_valid           normalized vertices valid (HOLD state)
//   busy                frame in progress (latch until handshake)
//   vtx_invalid[3:0]    bit i-1 set when vertex i had W == 0 (guard build)
//   vtx1_X..vtx4_Z      signed Q8.8 normalized coordinates
// Build option: define NORM_ZERO_W_GUARD_EN to skip W == 0 vertices
// (zero outputs, vtx_invalid flagged); otherwise they divide normally and
// saturate, and vtx_invalid is tied to 0.
// ---------------------------------------------------------------------------
module norm_divide_sched
    import norm_pkg::*;
#(
    parameter logic [3:0] READY_STATE = READY_STATE_DEF,
    parameter int         FRAC_BITS   = FRAC_BITS_DEF
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [3:0]  matrix_state,
    input  logic [15:0] d11, d12, d13, d14,
    input  logic [15:0] d21, d22, d23, d24,
    input  logic [15:0] d31, d32, d33, d34,
    input  logic [15:0] d41, d42, d43, d44,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        busy,
    output logic [3:0]  vtx_invalid,
    output logic [15:0] vtx1_X, vtx1_Y, vtx1_Z,
    output logic [15:0] vtx2_X, vtx2_Y, vtx2_Z,
    output logic [15:0] vtx3_X, vtx3_Y, vtx3_Z,
    output logic [15:0] vtx4_X, vtx4_Y, vtx4_Z
);

    state_t state, state_next;

    logic [3:0]                prev_ms;
    logic                      trig;
    logic signed [DATA_W-1:0]  din   [4][4];
    logic signed [DATA_W-1:0]  m     [4][4];
    logic signed [DATA_W-1:0]  res   [NUM_COMP];
    logic signed [DATA_W-1:0]  out_r [NUM_COMP];
    logic [3:0]                k;
    logic                      last;
    logic                      sign_r;
    logic [1:0]                vi, ci;
    logic signed [DATA_W-1:0]  num_sel, w_sel;
    logic [NUM_W-1:0]          div_num;
    logic [15:0]               div_den;
    logic                      div_start, div_done;
    logic [NUM_W-1:0]          quo;
    logic signed [DATA_W-1:0]  store_val;
    logic                      skip_first, skip_cur, skip_next;

    function automatic logic [15:0] abs16(input logic signed [15:0] v);
        // -32768 maps to 16'h8000, which is the correct unsigned magnitude.
        return v[15] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Clamp the quotient magnitude to 32767 before negation so the result is
    // symmetric (7FFF / 8001) and 8000 never appears.
    function automatic logic signed [15:0] sat_sign(input logic [23:0] q,
                                                    input logic        neg);
        if (|q[23:15]) begin
            return neg ? SAT_NEG : SAT_POS;
        end
        return neg ? -$signed({1'b0, q[14:0]}) : $signed({1'b0, q[14:0]});
    endfunction

    assign din = '{'{d11, d12, d13, d14},
                   '{d21, d22, d23, d24},
                   '{d31, d32, d33, d34},
                   '{d41, d42, d43, d44}};

    assign trig      = (matrix_state == READY_STATE) && (prev_ms != READY_STATE);
    assign last      = (k == 4'(NUM_COMP - 1));
    assign vi        = comp_vertex(k);
    assign ci        = comp_axis(k);
    assign num_sel   = m[vi][ci];
    assign w_sel     = m[vi][3];
    assign div_num   = NUM_W'(abs16(num_sel)) << FRAC_BITS;
    assign div_den   = abs16(w_sel);
    assign store_val = skip_cur ? '0 : sat_sign(quo, sign_r);

`ifdef NORM_ZERO_W_GUARD_EN
    logic [3:0] inv_r;
    logic [3:0] inv_out;

    // Decision for component 0 is made in LATCH, before m holds the matrix.
    assign skip_first  = (din[0][3] == '0);
    assign skip_cur    = (w_sel == '0);
    assign skip_next   = (m[comp_vertex(4'(k + 4'd1))][3] == '0);
    assign vtx_invalid = inv_out;

    always_ff @(posedge CLK) begin
        if (rst) begin
            inv_r   <= '0;
            inv_out <= '0;
        end else begin
            if (state == S_LATCH) begin
                inv_r <= '0;
            end
            if (state == S_STORE && skip_cur) begin
                inv_r[vi] <= 1'b1;
            end
            if (state == S_STORE && last) begin
                inv_out <= inv_r | (skip_cur ? (4'b0001 << vi) : 4'b0000);
            end
        end
    end
`else
    assign skip_first  = 1'b0;
    assign skip_cur    = 1'b0;
    assign skip_next   = 1'b0;
    assign vtx_invalid = 4'b0000;
`endif

    norm_serial_div u_div (
        .clk   (CLK),
        .rst   (rst),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .done  (div_done),
        .quo   (quo)
    );

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            S_IDLE:  if (trig) state_next = S_LATCH;
            S_LATCH: state_next = skip_first ? S_STORE : S_LOAD;
            S_LOAD: begin
                div_start  = 1'b1;
                state_next = S_DIV;
            end
            S_DIV:   if (div_done) state_next = S_STORE;
            S_STORE: begin
                if (last)           state_next = S_HOLD;
                else if (skip_next) state_next = S_STORE;
                else                state_next = S_LOAD;
            end
            S_HOLD:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state   <= S_IDLE;
            prev_ms <= '0;
            k       <= '0;
            sign_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    m[i][j] <= '0;
                end
            end
            for (int i = 0; i < NUM_COMP; i++) begin
                res[i]   <= '0;
                out_r[i] <= '0;
            end
        end else begin
            state   <= state_next;
            prev_ms <= matrix_state;
            case (state)
                S_LATCH: begin
                    m <= din;
                    k <= '0;
                end
                S_LOAD: sign_r <= num_sel[15] ^ w_sel[15];
                S_STORE: begin
                    res[k] <= store_val;
                    if (last) begin
                        // Final result is written this same edge, so take it
                        // straight from store_val rather than res.
                        for (int i = 0; i < NUM_COMP - 1; i++) begin
                            out_r[i] <= res[i];
                        end
                        out_r[NUM_COMP-1] <= store_val;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE);

    assign vtx1_X = out_r[0];
    assign vtx1_Y = out_r[1];
    assign vtx1_Z = out_r[2];
    assign vtx2_X = out_r[3];
    assign vtx2_Y = out_r[4];
    assign vtx2_Z = out_r[5];
    assign vtx3_X = out_r[6];
    assign vtx3_Y = out_r[7];
    assign vtx3_Z = out_r[8];
    assign vtx4_X = out_r[9];
    assign vtx4_Y = out_r[10];
    assign vtx4_Z = out_r[11];

endmodule

// File: tb/tb_norm_divide_sched.sv
// ---------------------------------------------------------------------------
// tb_norm_divide_sched
// Scoreboard bench for norm_divide_sched: expected quotients, vtx_invalid
// and trigger-to-valid latency are queued when a frame is launched and
// checked when out_valid rises. Honours NORM_ZERO_W_GUARD_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_norm_divide_sched;
    import norm_pkg::*;

    localparam logic [3:0] READY = 4'd5;
`ifdef NORM_ZERO_W_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  matrix_state;
    logic [15:0] d [4][4];
    logic        out_ready;
    logic        out_valid, busy;
    logic [3:0]  vtx_invalid;
    logic [15:0] vtx1_X, vtx1_Y, vtx1_Z, vtx2_X, vtx2_Y, vtx2_Z;
    logic [15:0] vtx3_X, vtx3_Y, vtx3_Z, vtx4_X, vtx4_Y, vtx4_Z;
    logic [15:0] got [12];

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_q [$];
    logic [3:0]  inv_q [$];
    int          lat_q [$];
    logic [15:0] last_exp [12];

    always #5 CLK = ~CLK;

    assign got[0]  = vtx1_X;
    assign got[1]  = vtx1_Y;
    assign got[2]  = vtx1_Z;
    assign got[3]  = vtx2_X;
    assign got[4]  = vtx2_Y;
    assign got[5]  = vtx2_Z;
    assign got[6]  = vtx3_X;
    assign got[7]  = vtx3_Y;
    assign got[8]  = vtx3_Z;
    assign got[9]  = vtx4_X;
    assign got[10] = vtx4_Y;
    assign got[11] = vtx4_Z;

    norm_divide_sched dut (
        .CLK          (CLK),
        .rst          (rst),
        .matrix_state (matrix_state),
        .d11 (d[0][0]), .d12 (d[0][1]), .d13 (d[0][2]), .d14 (d[0][3]),
        .d21 (d[1][0]), .d22 (d[1][1]), .d23 (d[1][2]), .d24 (d[1][3]),
        .d31 (d[2][0]), .d32 (d[2][1]), .d33 (d[2][2]), .d34 (d[2][3]),
        .d41 (d[3][0]), .d42 (d[3][1]), .d43 (d[3][2]), .d44 (d[3][3]),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .busy         (busy),
        .vtx_invalid  (vtx_invalid),
        .vtx1_X (vtx1_X), .vtx1_Y (vtx1_Y), .vtx1_Z (vtx1_Z),
        .vtx2_X (vtx2_X), .vtx2_Y (vtx2_Y), .vtx2_Z (vtx2_Z),
        .vtx3_X (vtx3_X), .vtx3_Y (vtx3_Y), .vtx3_Z (vtx3_Z),
        .vtx4_X (vtx4_X), .vtx4_Y (vtx4_Y), .vtx4_Z (vtx4_Z)
    );

    // Reference: exact integer Q8.8 division, truncated, clamped to 32767.
    function automatic logic [15:0] model_div(input logic signed [15:0] n,
                                              input logic signed [15:0] w);
        int an, aw, q;
        if (w == 0) begin
            if (GUARD) return 16'h0000;
            return (n >= 0) ? 16'h7FFF : 16'h8001;
        end
        an = (n < 0) ? -int'(n) : int'(n);
        aw = (w < 0) ? -int'(w) : int'(w);
        q  = (an * 256) / aw;
        if (q > 32767) q = 32767;
        if ((n < 0) != (w < 0)) q = -q;
        return 16'(q);
    endfunction

    task automatic push_expected();
        int         zeros;
        logic [3:0] inv;
        zeros = 0;
        inv   = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            if (GUARD && d[v][3] == 16'h0000) begin
                inv[v] = 1'b1;
                zeros++;
            end
            for (int c = 0; c < 3; c++) exp_q.push_back(model_div(d[v][c], d[v][3]));
        end
        inv_q.push_back(inv);
        lat_q.push_back(314 - 75 * zeros);
    endtask

    task automatic set_vertex(input int v, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] z, input logic [15:0] w);
        d[v][0] = x; d[v][1] = y; d[v][2] = z; d[v][3] = w;
    endtask

    task automatic random_matrix();
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < 4; c++) d[v][c] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d[v][3] = 16'($urandom_range(1, 255));
            if (d[v][3] == 16'h0000) d[v][3] = 16'h0100;
        end
    endtask

    // Launch the current matrix, check latency and results; optionally handshake.
    task automatic run_frame(input bit handshake);
        int         cnt;
        bit         seen;
        int         lat_exp;
        logic [3:0] inv_exp;
        logic [15:0] e;
        @(negedge CLK);
        matrix_state = 4'd0;
        push_expected();
        @(negedge CLK);
        matrix_state = READY;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 1000 && !seen) begin
            @(negedge CLK);
            cnt++;
            if (cnt == 1) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_after_trigger: got %b need 1", busy);
                end
            end
            if (out_valid === 1'b1) seen = 1'b1;
        end
        lat_exp = lat_q.pop_front();
        inv_exp = inv_q.pop_front();
        n_vec++;
        if (!seen || cnt != lat_exp) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles (valid seen %0b) need %0d", cnt, seen, lat_exp);
        end
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            last_exp[i] = e;
            n_vec++;
            if (got[i] !== e) begin
                n_bad++;
                $display("FAIL result[%0d]: got %h need %h", i, got[i], e);
            end
        end
        n_vec++;
        if (vtx_invalid !== inv_exp) begin
            n_bad++;
            $display("FAIL vtx_invalid: got %b need %b", vtx_invalid, inv_exp);
        end
        if (handshake) begin
            out_ready = 1'b1;
            @(negedge CLK);
            out_ready = 1'b0;
            n_vec++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL handshake_idle: got valid=%b busy=%b need 0/0", out_valid, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        matrix_state = 4'd0;
        out_ready = 1'b0;
        for (int v = 0; v < 4; v++) set_vertex(v, 16'h0, 16'h0, 16'h0, 16'h0100);
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || vtx_invalid !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b inv=%b need 0/0/0000",
                     out_valid, busy, vtx_invalid);
        end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (got[i] !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_out[%0d]: got %h need 0000", i, got[i]);
            end
        end
    endtask

    task automatic test_basic();
        set_vertex(0, 16'h0200, 16'h0100, 16'hFD00, 16'h0100);
        set_vertex(1, 16'h0100, 16'hFF00, 16'h0000, 16'h0200);
        set_vertex(2, 16'h0380, 16'hFFC0, 16'h1234, 16'h0100);
        set_vertex(3, 16'h8000, 16'h7FFF, 16'h0001, 16'h0100);
        run_frame(1'b1);
    endtask

    task automatic test_sign_sat_zero_w();
        set_vertex(0, 16'h0100, 16'h0200, 16'h0300, 16'h0100);
        set_vertex(1, 16'hFF00, 16'h0100, 16'h8000, 16'hFE00);
        set_vertex(2, 16'h7F00, 16'h8100, 16'h0000, 16'h0001);
        set_vertex(3, 16'h0005, 16'hFFFB, 16'h0000, 16'h0000);
        run_frame(1'b1);
    endtask

    task automatic test_hold_stall();
        bit ok;
        random_matrix();
        run_frame(1'b0);
        for (int i = 0; i < 50; i++) begin
            matrix_state = (i % 2 == 0) ? READY : 4'd0;
            @(negedge CLK);
            ok = (out_valid === 1'b1);
            for (int j = 0; j < 12; j++) if (got[j] !== last_exp[j]) ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL hold_stable cycle %0d: valid=%b vtx1_X=%h need valid=1 vtx1_X=%h",
                         i, out_valid, got[0], last_exp[0]);
            end
        end
        matrix_state = 4'd0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: got valid=%b busy=%b need 0/0", out_valid, busy);
        end
        repeat (5) @(negedge CLK);
        n_vec++;
        if (busy !== 1'b0 || got[5] !== last_exp[5] || got[11] !== last_exp[11]) begin
            n_bad++;
            $display("FAIL idle_after_stall: got busy=%b v2Z=%h v4Z=%h need 0 %h %h",
                     busy, got[5], got[11], last_exp[5], last_exp[11]);
        end
    endtask

    task automatic test_reset_midframe();
        random_matrix();
        @(negedge CLK);
        matrix_state = 4'd0;
        @(negedge CLK);
        matrix_state = READY;
        repeat (100) @(negedge CLK);
        rst = 1'b1;
        matrix_state = 4'd0;
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || vtx_invalid !== 4'b0000) begin
            n_bad++;
            $display("FAIL midframe_reset_ctrl: got valid=%b busy=%b inv=%b need 0/0/0000",
                     out_valid, busy, vtx_invalid);
        end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (got[i] !== 16'h0000) begin
                n_bad++;
                $display("FAIL midframe_reset_out[%0d]: got %h need 0000", i, got[i]);
            end
        end
        random_matrix();
        run_frame(1'b1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            random_matrix();
            run_frame(1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_sign_sat_zero_w();
        test_hold_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/norm_divide_sched.md
# norm_divide_sched

Sequencer for the vertex normalization (perspective-divide) stage of the render pipeline. Latches a 4x4 clip-space matrix (one vertex per row: X, Y, Z, W) when the matrix unit reports it ready. Time-shares one serial divider across all 12 X/W, Y/W, Z/W quotients. Presents the 4 normalized vertices with a valid/ready handshake to the downstream stage.

## Interface
- READY_STATE, 4'd5, `matrix_state` value meaning "matrix product valid".
- FRAC_BITS, 8, fractional bits of the signed Q8.8 data format.
- CLK  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- matrix_state  in  4  matrix unit state; entry into READY_STATE triggers a frame.
- d11..d44  in  16 each, signed Q8.8; row i = vertex i: di1=X, di2=Y, di3=Z, di4=W.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  result vertices valid.
- busy  out  1  high from latch until handshake completes.
- vtx_invalid  out  4  bit i-1 set when vertex i had W==0 (guard build only).
- vtx1_X..vtx4_Z  out  16 each, signed Q8.8 normalized coordinates.

## Operation
- Trigger: `matrix_state==READY_STATE` while the previous-cycle copy was not READY_STATE. The previous-cycle register resets to 0, so READY_STATE present at reset release triggers.
- Trigger is honoured only in IDLE. Triggers in any other state are dropped, not queued.
- FSM states: IDLE, LATCH, LOAD, DIV, STORE, HOLD.
  - IDLE→LATCH on trigger.
  - LATCH: capture all 16 inputs, clear the component index k=0, go to LOAD.
  - LOAD: numerator = |num_k|<<FRAC_BITS (24-bit magnitude), divisor = |W|, sign = sign(num_k) XOR sign(W); go to DIV.
  - DIV: 24 restoring iterations, one quotient bit per cycle; then STORE.
  - STORE: saturate, apply sign, write result register k. If k==11, go to HOLD; else k++ and go to LOAD.
  - HOLD: copy all 12 result registers to outputs on entry and assert out_valid. On out_valid&&out_ready, go to IDLE next cycle.
- Component order: v1 X,Y,Z, v2 X,Y,Z, … v4 Z.
- Saturation: quotient magnitude >32767 gives 32767, then sign applied, so results are 16'h7FFF or 16'h8001. 16'h8000 is never produced.
- Zero numerator gives 0 regardless of sign.
- Outputs change only on HOLD entry and hold their value through IDLE until the next frame.
- out_ready low in HOLD: out_valid and outputs stay stable indefinitely.
- Reset mid-operation: abort. State IDLE, every output and internal register 0.

## Timing
- Reset values: out_valid=0, busy=0, vtx_invalid=0, all vtx outputs 0.
- Per component: LOAD 1 + DIV 24 + STORE 1 = 26 cycles.
- out_valid rises 314 cycles after the trigger edge (cycles: IDLE 1, LATCH 1, 12×26).
- busy rises the cycle after the trigger edge and falls with the handshake.
- Earliest next trigger is accepted the cycle after returning to IDLE.
- Guard build, W==0 vertex: its 3 components skip LOAD/DIV and take 1 STORE cycle each, saving 75 cycles per such vertex.

## Configuration
- NORM_ZERO_W_GUARD_EN defined: W==0 vertices are skipped as above, their outputs are 0 and their vtx_invalid bit is set.
- NORM_ZERO_W_GUARD_EN undefined: W==0 runs the normal divide, and the all-ones quotient saturates.
  - Result is 16'h7FFF for a numerator >=0, 16'h8001 for a negative numerator.
  - vtx_invalid is tied to 0.

## Structure
- Package `norm_pkg`:
  - FSM state enum.
  - Default FRAC_BITS.
  - Constants SAT_POS=16'h7FFF, SAT_NEG=16'h8001.
  - Component count 12 and DIV_ITERS=24.
- Sub-module `norm_serial_div`: unsigned 24/16 restoring divider with start/done. It owns the iteration counter; the sequencer owns sign and saturation.

## Test plan
- v1 = (X=0x0200, Y=0x0100, Z=0xFD00, W=0x0100), other vertices W=0x0100 → vtx1 = 0x0200, 0x0100, 0xFD00; out_valid exactly 314 cycles after trigger.
- v2 X=0x0100, W=0x0200 → 0x0080; X=0xFF00, W=0xFE00 → 0x0080.
- v3 X=0x7F00, W=0x0001 → 0x7FFF; X=0x8100, W=0x0001 → 0x8001.
- v4 W=0, X=5, Y=-5:
  - Guard build → outputs 0, vtx_invalid=4'b1000, out_valid at 239 cycles.
  - Non-guard build → 0x7FFF and 0x8001.
- out_ready held low 50 cycles in HOLD with matrix_state toggled through READY_STATE → outputs stable, no new frame. Assert out_ready → IDLE next cycle.
- rst pulsed at cycle 100 of a frame → all outputs 0, IDLE. A fresh trigger then completes normally.
